// File: rtl/div_unit.sv
// div_unit -- iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
//
// Takes the rs1/rs2 operands read from register32 and produces the write-back
// triple (wb_rd, wb_data, wb_we) that drives register32's write port. One
// radix-2 restoring step runs per cycle, so a normal operation spends XLEN
// cycles in RUN and one cycle in DONE. Divide-by-zero and signed overflow
// skip RUN and go straight to DONE.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op         launch request and opcode (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   rs1_val, rs2_val  dividend / divisor
//   rd_addr           destination register
//   kill              flush of the operation in flight (wins over start)
//   busy              high in every state except IDLE
//   wb_we, wb_rd      one-cycle write strobe in DONE and destination register
//   wb_data           result; holds its value until the next completed DONE
//   dbg_state_o       current FSM state for checkers
//
// Handshake: start is a request with no back-pressure signal of its own. It is
// accepted on a rising edge where the unit is IDLE (busy==0) and kill is low;
// a start seen while busy is dropped, and the operands are not re-sampled.
// The issue stage must hold dependent instructions while busy is high.

module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  input  logic            kill,
  output logic            busy,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [1:0]      dbg_state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  logic [1:0]       state_q,    state_d;
  logic [1:0]       op_q,       op_d;
  logic [4:0]       rd_q,       rd_d;
  logic [XLEN-1:0]  quo_q,      quo_d;
  logic [XLEN-1:0]  acc_q,      acc_d;
  logic [XLEN-1:0]  dvs_q,      dvs_d;
  logic             neg_quo_q,  neg_quo_d;
  logic             neg_rem_q,  neg_rem_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [XLEN-1:0]  wb_data_q,  wb_data_d;

  // Operand conditioning at accept time.
  logic            signed_op;
  logic            sign1, sign2;
  logic [XLEN-1:0] abs1, abs2;
  logic            div_zero, sgn_ovf;

  assign signed_op = ~op[0];
  assign sign1     = signed_op & rs1_val[XLEN-1];
  assign sign2     = signed_op & rs2_val[XLEN-1];
  assign abs1      = sign1 ? -rs1_val : rs1_val;
  assign abs2      = sign2 ? -rs2_val : rs2_val;
  assign div_zero  = (rs2_val == '0);
  assign sgn_ovf   = signed_op && (rs1_val == MIN_NEG) && (rs2_val == ALL_ONES);

  // One restoring step. The dividend is shifted out of quo_q into the
  // partial remainder while quotient bits are shifted in at the bottom.
  logic [XLEN:0]   acc_sh;
  logic            step_ge;
  logic [XLEN-1:0] trial;

  assign acc_sh  = {acc_q, quo_q[XLEN-1]};
  assign step_ge = (acc_sh >= {1'b0, dvs_q});
  // When step_ge is set the true difference is below the divisor, so the
  // low XLEN bits carry it exactly.
  assign trial   = acc_sh[XLEN-1:0] - dvs_q;

  // Result selection in DONE. Special cases load neg flags as 0, so the
  // preloaded quotient/remainder pass straight through.
  logic [XLEN-1:0] res_mag;
  logic            res_neg;
  logic [XLEN-1:0] result;
  logic            done_live;

  assign res_mag   = op_q[1] ? acc_q : quo_q;
  assign res_neg   = op_q[1] ? neg_rem_q : neg_quo_q;
  assign result    = res_neg ? -res_mag : res_mag;
  // A kill arriving in DONE suppresses the write and leaves wb_data alone.
  assign done_live = (state_q == ST_DONE) && !kill;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    quo_d     = quo_q;
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;

    if (kill) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_d  = op;
            rd_d  = rd_addr;
            dvs_d = abs2;
            cnt_d = '0;
            if (div_zero) begin
              quo_d     = ALL_ONES;
              acc_d     = rs1_val;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = ST_DONE;
            end else if (sgn_ovf) begin
              quo_d     = MIN_NEG;
              acc_d     = '0;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = ST_DONE;
            end else begin
              quo_d     = abs1;
              acc_d     = '0;
              neg_quo_d = sign1 ^ sign2;
              neg_rem_d = sign1;
              state_d   = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          acc_d = step_ge ? trial : acc_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], step_ge};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          wb_data_d = result;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      quo_q     <= '0;
      acc_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      quo_q     <= quo_d;
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign wb_we       = done_live && (rd_q != 5'd0);
  assign wb_rd       = rd_q;
  // During DONE the fresh result is shown directly so it lines up with wb_we.
  assign wb_data     = done_live ? result : wb_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  localparam int XLEN = 32;
  localparam int NORMAL_LAT = XLEN + 1;
  localparam int MAX_WAIT = 100;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] rs1_val = '0;
  logic [XLEN-1:0] rs2_val = '0;
  logic [4:0]      rd_addr = '0;
  logic            kill = 1'b0;
  logic            busy;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .rd_addr     (rd_addr),
    .kill        (kill),
    .busy        (busy),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_wb = '0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // RV32M semantics straight from the ISA rules, using native arithmetic.
  function automatic logic [XLEN-1:0] ref_result(input logic [1:0] f_op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    if (b == 0) return f_op[1] ? a : 32'hFFFF_FFFF;
    if (!f_op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return f_op[1] ? 32'h0 : 32'h8000_0000;
      return f_op[1] ? XLEN'(sa % sb) : XLEN'(sa / sb);
    end
    return f_op[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit is_special(input logic [1:0] f_op,
                                    input logic [XLEN-1:0] a,
                                    input logic [XLEN-1:0] b);
    return (b == 0) || (!f_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // ---------------- driver ----------------
  // Called just after a negedge. poke>0 raises a second start (with other
  // operands) in that cycle of the operation, which must be ignored.
  task automatic run_op(input string tag, input logic [1:0] f_op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [4:0] rd, input int poke);
    int lat;
    int cyc;
    bit seen;
    bit done;
    logic [XLEN-1:0] exp;
    lat = is_special(f_op, a, b) ? 1 : NORMAL_LAT;
    exp_q.push_back(ref_result(f_op, a, b));
    op = f_op; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
    cyc = 0; seen = 0; done = 0;
    while (!done && cyc < MAX_WAIT) begin
      @(negedge clk);
      cyc++;
      start = (poke > 0 && cyc == poke);
      if (start) begin
        op = ~f_op; rs1_val = $urandom; rs2_val = 32'd3; rd_addr = rd ^ 5'd1;
      end
      if (cyc == 1) check({tag, " busy_after_accept"}, XLEN'(busy), 1);
      if (wb_we) begin
        seen = 1;
        done = 1;
      end else if (!busy) begin
        done = 1;
      end
    end
    exp = exp_q.pop_front();
    if (rd != 0) begin
      check({tag, " latency"}, XLEN'(cyc), XLEN'(lat));
      check({tag, " wb_rd"}, XLEN'(wb_rd), XLEN'(rd));
      check({tag, " wb_data"}, wb_data, exp);
      @(negedge clk);
      check({tag, " busy_clear"}, XLEN'(busy), 0);
      check({tag, " we_one_cycle"}, XLEN'(wb_we), 0);
    end else begin
      check({tag, " rd0_no_we"}, XLEN'(seen), 0);
      check({tag, " rd0_busy_len"}, XLEN'(cyc), XLEN'(lat + 1));
    end
    last_wb = exp;
    start = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cyc;
    bit seen;
    logic [1:0] r_op;
    logic [XLEN-1:0] a, b;
    int mode;

    // Reset state
    @(negedge clk);
    check("reset busy", XLEN'(busy), 0);
    check("reset wb_we", XLEN'(wb_we), 0);
    check("reset wb_rd", XLEN'(wb_rd), 0);
    check("reset wb_data", wb_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1. unsigned divide / remainder
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5, 0);
    // 2. signed
    run_op("div_m7_2", 2'b00, -32'sd7, 32'd2, 5'd6, 0);
    run_op("rem_m7_2", 2'b10, -32'sd7, 32'd2, 5'd7, 0);
    run_op("rem_7_m2", 2'b10, 32'd7, -32'sd2, 5'd8, 0);
    // 3. divide by zero
    run_op("divu_by0", 2'b01, 32'd123, 32'd0, 5'd9, 0);
    run_op("rem_by0", 2'b10, 32'd123, 32'd0, 5'd10, 0);
    // 4. signed overflow
    run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
    // DIVU with the same bits is not special
    run_op("divu_big", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0);

    // 5. kill in RUN cycle 10
    op = 2'b01; rs1_val = 32'd5000; rs2_val = 32'd3; rd_addr = 5'd14; start = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (wb_we) seen = 1;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy_low", XLEN'(busy), 0);
    check("kill no_we", XLEN'(seen | wb_we), 0);
    check("kill wb_data_kept", wb_data, last_wb);
    run_op("after_kill", 2'b01, 32'd5000, 32'd3, 5'd14, 0);

    // kill and start together in IDLE: start dropped
    op = 2'b01; rs1_val = 32'd9; rs2_val = 32'd2; rd_addr = 5'd3;
    start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("idle_kill busy", XLEN'(busy), 0);
    @(negedge clk);
    check("idle_kill still_idle", XLEN'(busy), 0);

    // kill while in DONE: no write, wb_data retained
    op = 2'b01; rs1_val = 32'd77; rs2_val = 32'd0; rd_addr = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kill = 1'b1;
    #1;
    check("done_kill no_we", XLEN'(wb_we), 0);
    @(negedge clk);
    kill = 1'b0;
    check("done_kill busy", XLEN'(busy), 0);
    check("done_kill data_kept", wb_data, last_wb);

    // 6. rd=0 and start-while-busy
    run_op("rd0", 2'b00, 32'd1000, 32'd10, 5'd0, 0);
    run_op("rd0_special", 2'b01, 32'd1, 32'd0, 5'd0, 0);
    run_op("poke_busy", 2'b01, 32'd999, 32'd4, 5'd15, 5);

    // back-to-back: start immediately once busy is low
    run_op("b2b_a", 2'b00, -32'sd100, 32'd9, 5'd16, 0);
    run_op("b2b_b", 2'b10, -32'sd100, 32'd9, 5'd17, 0);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = 0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = 32'($urandom_range(1, 15));
      else if (mode == 3) b = b >> $urandom_range(0, 31);
      run_op("random", r_op, a, b, 5'($urandom_range(0, 31)), 0);
    end

    // reset mid-RUN: outputs return to zero immediately
    op = 2'b00; rs1_val = 32'd12345; rs2_val = 32'd7; rd_addr = 5'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid busy", XLEN'(busy), 0);
    check("rst_mid wb_we", XLEN'(wb_we), 0);
    check("rst_mid wb_rd", XLEN'(wb_rd), 0);
    check("rst_mid wb_data", wb_data, 0);
    seen = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (wb_we) seen = 1;
    end
    check("rst_mid no_we", XLEN'(seen), 0);
    rst_n = 1'b1;
    last_wb = '0;
    @(negedge clk);
    run_op("after_reset", 2'b00, -32'sd12345, 32'd7, 5'd21, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
